// File: rtl/prog_counter_pkg.sv
// Shared constants for the programmable up/down counter.
// Mode encodings and the supported WIDTH range.
package prog_counter_pkg;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;
endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count and boundary-event logic for prog_counter.
// Priority: clear > load > enable > hold.
import prog_counter_pkg::*;

module prog_counter_next #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_value,
  output logic [WIDTH-1:0] count_next,
  output logic             boundary
);

  always_comb begin
    count_next = count;
    boundary   = 1'b0;
    if (clear) begin
      count_next = '0;
    end else if (load) begin
      count_next = (load_value > max_value) ? max_value : load_value;
    end else if (enable) begin
      if (up_down) begin
        if (count < max_value) begin
          count_next = count + 1'b1;
        end else begin
          boundary   = 1'b1;
          count_next = (mode == MODE_SATURATE) ? max_value : '0;
        end
      end else begin
        // A count stranded above a lowered max snaps back without a boundary event.
        if (count > max_value) begin
          count_next = max_value;
        end else if (count == '0) begin
          boundary   = 1'b1;
          count_next = (mode == MODE_SATURATE) ? '0 : max_value;
        end else begin
          count_next = count - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with wrap/saturate modes, terminal-count pulse
// and sticky overflow flag; all state lives here, next-state logic in prog_counter_next.
import prog_counter_pkg::*;

module prog_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_value,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             overflow,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] count_next;
  logic             boundary;

  prog_counter_next #(.WIDTH(WIDTH)) u_next (
    .count      (count),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .up_down    (up_down),
    .mode       (mode),
    .max_value  (max_value),
    .count_next (count_next),
    .boundary   (boundary)
  );

  // A boundary event in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      tc       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      count <= count_next;
      tc    <= boundary;
      if (boundary)
        overflow <= 1'b1;
      else if (ovf_clr)
        overflow <= 1'b0;
    end
  end

  assign at_max  = (count == max_value);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed scenarios plus randomized traffic
// checked against a behavioural model of the counting rules.
module tb_prog_counter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0, clear = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         up_down = 1'b1, mode = 1'b0;
  logic [W-1:0] max_value = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] count;
  logic         tc, overflow, at_max, at_zero;

  prog_counter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
    .load_value(load_value), .up_down(up_down), .mode(mode), .max_value(max_value),
    .ovf_clr(ovf_clr), .count(count), .tc(tc), .overflow(overflow),
    .at_max(at_max), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    cnt;
    bit    tc;
    bit    ovf;
    bit    amax;
    bit    azero;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference state
  int m_count = 0;
  bit m_ovf   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at negedge and queue the expected post-edge outputs.
  task automatic cyc(input bit en, input bit clr, input bit ld, input int lv,
                     input bit ud, input bit md, input int mx, input bit oc,
                     input string tag);
    exp_t e;
    bit   bnd;
    @(negedge clk);
    enable = en; clear = clr; load = ld; load_value = W'(lv);
    up_down = ud; mode = md; max_value = W'(mx); ovf_clr = oc;
    bnd = 0;
    if (clr)
      m_count = 0;
    else if (ld)
      m_count = (lv < mx) ? lv : mx;
    else if (en) begin
      if (ud) begin
        if (m_count < mx) m_count = m_count + 1;
        else begin bnd = 1; m_count = md ? mx : 0; end
      end else begin
        if (m_count > mx) m_count = mx;
        else if (m_count == 0) begin bnd = 1; m_count = md ? 0 : mx; end
        else m_count = m_count - 1;
      end
    end
    if (bnd) m_ovf = 1;
    else if (oc) m_ovf = 0;
    e.cnt = m_count; e.tc = bnd; e.ovf = m_ovf;
    e.amax = (m_count == mx); e.azero = (m_count == 0); e.tag = tag;
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle once a transaction is queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.tag, ".count"},   32'(count),    32'(e.cnt));
        check({e.tag, ".tc"},      32'(tc),       32'(e.tc));
        check({e.tag, ".ovf"},     32'(overflow), 32'(e.ovf));
        check({e.tag, ".at_max"},  32'(at_max),   32'(e.amax));
        check({e.tag, ".at_zero"}, 32'(at_zero),  32'(e.azero));
      end
    end
  end

  initial begin
    int mx, lv;
    #12;
    check("rst.count", 32'(count), 0);
    check("rst.tc", 32'(tc), 0);
    check("rst.ovf", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    // Up count, WRAP, max 9, 12 enabled cycles.
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 1, 0, 9, 0, "wrap_up");

    // Down, SATURATE from 2, then overflow clear behaviour.
    cyc(0, 0, 1, 2, 0, 1, 9, 0, "sat_load");
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 1, 9, 0, "sat_dn");
    cyc(0, 0, 0, 0, 0, 1, 9, 1, "ovf_clr");
    cyc(1, 0, 0, 0, 0, 1, 9, 1, "ovf_clr_bnd");

    // Load clamp and clear priority.
    cyc(0, 0, 1, 250, 1, 0, 200, 0, "ld_clamp");
    cyc(0, 1, 1, 250, 1, 0, 200, 0, "clr_vs_ld");

    // Lowered max at run time.
    cyc(0, 0, 1, 150, 1, 0, 200, 0, "ld150");
    cyc(1, 0, 0, 0, 1, 0, 100, 0, "lower_up_wrap");
    cyc(0, 0, 1, 150, 1, 0, 200, 0, "ld150");
    cyc(1, 0, 0, 0, 1, 1, 100, 0, "lower_up_sat");
    cyc(0, 0, 1, 150, 1, 0, 200, 0, "ld150");
    cyc(1, 0, 0, 0, 0, 0, 100, 0, "lower_dn");

    // max 0: every enabled step is a boundary.
    cyc(0, 1, 0, 0, 1, 0, 0, 0, "max0_clr");
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, i[0], i[1], 0, 0, "max0");

    // Async reset mid-cycle with count=7, tc=1, overflow=1.
    cyc(0, 0, 1, 7, 1, 1, 7, 1, "pre_rst_ld");
    cyc(1, 0, 0, 0, 1, 1, 7, 0, "pre_rst_sat");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst.count", 32'(count), 0);
    check("async_rst.tc", 32'(tc), 0);
    check("async_rst.ovf", 32'(overflow), 0);
    m_count = 0; m_ovf = 0;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    cyc(1, 0, 0, 0, 1, 0, 9, 0, "post_rst_up");

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      mx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
      lv = int'($urandom_range(0, 255));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, lv,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mx,
          $urandom_range(0, 7) == 0, "rand");
    end

    repeat (3) @(posedge clk);
    #2;
    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
